// File: rtl/pair_strobe_pkg.sv
// Shared types and helpers for the paired strobe generator.
package pair_strobe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StSingle = 2'd1;
  localparam state_t StBoth   = 2'd2;

  localparam int unsigned ChA = 0;
  localparam int unsigned ChB = 1;

  function automatic int unsigned pend_width(input int unsigned max_pend);
    int unsigned w;
    w = $clog2(max_pend + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pair_strobe_gen_if.sv
// Request/strobe/status bundle between a requester and the strobe generator.
interface pair_strobe_gen_if #(
  parameter int unsigned PEND_W = 3,
  parameter int unsigned STAT_W = 16
) ();

  logic              req_a;
  logic              req_b;
  logic              signal_a;
  logic              signal_b;
  logic [PEND_W-1:0] pend_a;
  logic [PEND_W-1:0] pend_b;
  logic              ovf_a;
  logic              ovf_b;
  logic [STAT_W-1:0] coinc_cnt;
  logic [STAT_W-1:0] defer_cnt;

  modport master (
    output req_a, req_b,
    input  signal_a, signal_b, pend_a, pend_b, ovf_a, ovf_b, coinc_cnt, defer_cnt
  );

  modport slave (
    input  req_a, req_b,
    output signal_a, signal_b, pend_a, pend_b, ovf_a, ovf_b, coinc_cnt, defer_cnt
  );

endinterface

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with a sticky flag for increments lost at the ceiling.
module sat_updown_cnt #(
  parameter int unsigned       Width = 3,
  parameter logic [Width-1:0]  Max   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             ovf_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Simultaneous inc and dec cancel, so a full counter that also drains never overflows.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == Max) ovf_d = 1'b1;
      else              cnt_d = cnt_q + 1'b1;
    end else if (!inc_i && dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pair_strobe_gen.sv
// Paired strobe generator: queues requests per channel and never drives both
// strobes high in two consecutive cycles, alternating fairly when both are pending.
module pair_strobe_gen
  import pair_strobe_pkg::*;
#(
  parameter int unsigned MAX_PEND = 7,
  parameter int unsigned STAT_W   = 16
) (
  input logic              clk,
  input logic              reset,
  pair_strobe_gen_if.slave bus
);

  localparam int unsigned PendW = pend_width(MAX_PEND);

  logic [1:0]       req, want, issue, sig_q;
  logic [PendW-1:0] pend_a, pend_b;
  logic             ovf_a, ovf_b;
  logic             defer;
  state_t           state_q, state_d;
  logic             pri_q, pri_d;

  assign req[ChA]  = bus.req_a;
  assign req[ChB]  = bus.req_b;
  assign want[ChA] = (pend_a != '0);
  assign want[ChB] = (pend_b != '0);

  always_comb begin
    issue = want;
    defer = 1'b0;
    pri_d = pri_q;
    if (state_q == StBoth && want[ChA] && want[ChB]) begin
      issue[ChA] = ~pri_q;
      issue[ChB] = pri_q;
      defer      = 1'b1;
      pri_d      = ~pri_q;
    end
  end

  always_comb begin
    unique case (issue)
      2'b11:        state_d = StBoth;
      2'b01, 2'b10: state_d = StSingle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pri_q   <= 1'b0;
      sig_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      sig_q   <= issue;
    end
  end

  sat_updown_cnt #(
    .Width (PendW),
    .Max   (PendW'(MAX_PEND))
  ) u_pend_a (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (req[ChA]),
    .dec_i (issue[ChA]),
    .cnt_o (pend_a),
    .ovf_o (ovf_a)
  );

  sat_updown_cnt #(
    .Width (PendW),
    .Max   (PendW'(MAX_PEND))
  ) u_pend_b (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (req[ChB]),
    .dec_i (issue[ChB]),
    .cnt_o (pend_b),
    .ovf_o (ovf_b)
  );

  sat_updown_cnt #(
    .Width (STAT_W)
  ) u_coinc_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (issue[ChA] & issue[ChB]),
    .dec_i (1'b0),
    .cnt_o (bus.coinc_cnt),
    .ovf_o ()
  );

  sat_updown_cnt #(
    .Width (STAT_W)
  ) u_defer_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (defer),
    .dec_i (1'b0),
    .cnt_o (bus.defer_cnt),
    .ovf_o ()
  );

  assign bus.signal_a = sig_q[ChA];
  assign bus.signal_b = sig_q[ChB];
  assign bus.pend_a   = pend_a;
  assign bus.pend_b   = pend_b;
  assign bus.ovf_a    = ovf_a;
  assign bus.ovf_b    = ovf_b;

endmodule

// File: tb/tb_pair_strobe_gen.sv
// Bench for pair_strobe_gen: directed scenarios plus random traffic against a queue-count model.
module tb_pair_strobe_gen;
  import pair_strobe_pkg::*;

  localparam int unsigned MAX_PEND = 7;
  localparam int unsigned STAT_W   = 16;
  localparam int unsigned PEND_W   = pend_width(MAX_PEND);
  localparam int          STAT_MAX = (1 << STAT_W) - 1;

  logic clk;
  logic reset;

  pair_strobe_gen_if #(.PEND_W(PEND_W), .STAT_W(STAT_W)) bus ();

  pair_strobe_gen #(
    .MAX_PEND (MAX_PEND),
    .STAT_W   (STAT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks, n_pass;

  // Reference state: queue depths, last output pair, whose turn it is when both are blocked.
  int m_pend_a, m_pend_b, m_sig_a, m_sig_b, m_turn;
  int m_ovf_a, m_ovf_b, m_coinc, m_defer, m_drop_a, m_drop_b;
  int n_req_a, n_req_b, n_strobe_a, n_strobe_b;
  logic prev_both;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic model_step(input int ra, input int rb, input int rs);
    int wa, wb, ia, ib;
    if (rs != 0) begin
      m_pend_a = 0; m_pend_b = 0; m_sig_a = 0; m_sig_b = 0; m_turn = 0;
      m_ovf_a = 0; m_ovf_b = 0; m_coinc = 0; m_defer = 0;
      return;
    end
    wa = (m_pend_a > 0) ? 1 : 0;
    wb = (m_pend_b > 0) ? 1 : 0;
    if (m_sig_a == 1 && m_sig_b == 1 && wa == 1 && wb == 1) begin
      ia = (m_turn == 0) ? 1 : 0;
      ib = 1 - ia;
      m_turn = 1 - m_turn;
      if (m_defer < STAT_MAX) m_defer++;
    end else begin
      ia = wa;
      ib = wb;
    end
    if (ia == 1 && ib == 1 && m_coinc < STAT_MAX) m_coinc++;
    m_pend_a = m_pend_a - ia + ra;
    m_pend_b = m_pend_b - ib + rb;
    if (m_pend_a > int'(MAX_PEND)) begin
      m_pend_a = MAX_PEND; m_ovf_a = 1; m_drop_a++;
    end
    if (m_pend_b > int'(MAX_PEND)) begin
      m_pend_b = MAX_PEND; m_ovf_b = 1; m_drop_b++;
    end
    m_sig_a = ia;
    m_sig_b = ib;
  endtask

  task automatic step(input logic ra, input logic rb, input logic rs);
    logic both;
    bus.req_a = ra;
    bus.req_b = rb;
    reset     = rs;
    @(posedge clk);
    model_step(int'(ra), int'(rb), int'(rs));
    if (!rs) begin
      n_req_a += int'(ra);
      n_req_b += int'(rb);
    end
    #1;
    check_eq("signal_a", 32'(bus.signal_a), 32'(m_sig_a));
    check_eq("signal_b", 32'(bus.signal_b), 32'(m_sig_b));
    check_eq("pend_a", 32'(bus.pend_a), 32'(m_pend_a));
    check_eq("pend_b", 32'(bus.pend_b), 32'(m_pend_b));
    check_eq("ovf_a", 32'(bus.ovf_a), 32'(m_ovf_a));
    check_eq("ovf_b", 32'(bus.ovf_b), 32'(m_ovf_b));
    check_eq("coinc_cnt", 32'(bus.coinc_cnt), 32'(m_coinc));
    check_eq("defer_cnt", 32'(bus.defer_cnt), 32'(m_defer));
    both = bus.signal_a & bus.signal_b;
    check_eq("rule_both_twice", 32'(prev_both & both), 32'd0);
    prev_both  = both;
    n_strobe_a += int'(bus.signal_a);
    n_strobe_b += int'(bus.signal_b);
  endtask

  logic [1:0] exp_pat [3];
  int         hi_cnt;

  initial begin
    clk = 1'b0; reset = 1'b1; bus.req_a = 1'b0; bus.req_b = 1'b0;
    n_checks = 0; n_pass = 0; prev_both = 1'b0;
    m_drop_a = 0; m_drop_b = 0; n_req_a = 0; n_req_b = 0; n_strobe_a = 0; n_strobe_b = 0;

    // Single pair
    step(0, 0, 1);
    check_eq("reset_sig", {30'd0, bus.signal_a, bus.signal_b}, 32'd0);
    step(1, 1, 0);
    check_eq("t1_no_early", {30'd0, bus.signal_a, bus.signal_b}, 32'd0);
    step(0, 0, 0);
    check_eq("t1_pair", {30'd0, bus.signal_a, bus.signal_b}, 32'd3);
    step(0, 0, 0);
    check_eq("t1_after", {30'd0, bus.signal_a, bus.signal_b}, 32'd0);
    check_eq("t1_coinc", 32'(bus.coinc_cnt), 32'd1);
    check_eq("t1_defer", 32'(bus.defer_cnt), 32'd0);

    // Back-to-back pairs
    step(0, 0, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    check_eq("t2_first", {30'd0, bus.signal_a, bus.signal_b}, 32'd3);
    exp_pat[0] = 2'b10; exp_pat[1] = 2'b01; exp_pat[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check_eq("t2_pattern", {30'd0, bus.signal_a, bus.signal_b}, 32'(exp_pat[i]));
    end
    check_eq("t2_defer", 32'(bus.defer_cnt), 32'd1);

    // Single channel burst
    step(0, 0, 1);
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(i < 4, 0, 0);
      hi_cnt += int'(bus.signal_a);
      check_eq("t3_b_low", 32'(bus.signal_b), 32'd0);
    end
    check_eq("t3_a_cycles", 32'(hi_cnt), 32'd4);
    check_eq("t3_defer", 32'(bus.defer_cnt), 32'd0);

    // Sustained demand on both channels drives the queues into saturation
    step(0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 1, 0);
    check_eq("t4_pend_a_sat", 32'(bus.pend_a), 32'(MAX_PEND));
    check_eq("t4_ovf_a", 32'(bus.ovf_a), 32'd1);

    // Reset with work still queued
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    check_eq("t5_sig", {30'd0, bus.signal_a, bus.signal_b}, 32'd0);
    check_eq("t5_pend", {26'd0, bus.pend_a, bus.pend_b}, 32'd0);
    check_eq("t5_flags", {30'd0, bus.ovf_a, bus.ovf_b}, 32'd0);
    check_eq("t5_coinc", 32'(bus.coinc_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      check_eq("t5_quiet", {30'd0, bus.signal_a, bus.signal_b}, 32'd0);
    end

    // Random traffic with varying densities, then drain and balance the books
    m_drop_a = 0; m_drop_b = 0; n_req_a = 0; n_req_b = 0; n_strobe_a = 0; n_strobe_b = 0;
    for (int ph = 0; ph < 10; ph++) begin
      int dens_a, dens_b;
      dens_a = int'($urandom_range(5, 95));
      dens_b = int'($urandom_range(5, 95));
      for (int i = 0; i < 1000; i++)
        step(int'($urandom_range(0, 99)) < dens_a, int'($urandom_range(0, 99)) < dens_b, 0);
    end
    for (int i = 0; i < 60; i++) step(0, 0, 0);
    check_eq("sb_strobes_a", 32'(n_strobe_a), 32'(n_req_a - m_drop_a));
    check_eq("sb_strobes_b", 32'(n_strobe_b), 32'(n_req_b - m_drop_b));
    check_eq("sb_drained", {26'd0, bus.pend_a, bus.pend_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
